// File: rtl/led_fader_if.sv
// led_fader_if: pattern/load request and LED/busy status between pattern source and led_fader
// pattern_in  : target on/off pattern, bit i = LED i
// load        : single-cycle strobe latching pattern_in
// led         : registered PWM outputs to the pins
// busy        : any LED still fading toward its target
interface led_fader_if;
    logic [7:0] pattern_in;
    logic       load;
    logic [7:0] led;
    logic       busy;
    modport master (output pattern_in, load, input led, busy);
    modport slave  (input pattern_in, load, output led, busy);
endinterface

// File: rtl/led_fader.sv
// led_fader: per-LED PWM brightness fader ramping each LED one step per prescaler tick toward its target
// clk : system clock
// rst : asynchronous active-high reset
// bus : led_fader_if.slave (pattern_in, load in; led, busy out)
module led_fader #(
    parameter int PWM_BITS    = 4,
    parameter int STEP_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    led_fader_if.slave  bus
);
    localparam int PW = $clog2(STEP_CYCLES);
    localparam logic [PWM_BITS-1:0] MAX = '1;
    logic [7:0]          target;
    logic [PWM_BITS-1:0] level [8];
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PW-1:0]       presc;
    logic [7:0]          led_q;
    logic                busy_c;
    logic                tick;
    assign tick = presc == PW'(STEP_CYCLES - 1);
    // the step reads the pre-edge target, so a load coinciding with a tick only affects the next tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target  <= '0;
            pwm_cnt <= '0;
            presc   <= '0;
            led_q   <= '0;
            for (int i = 0; i < 8; i++) level[i] <= '0;
        end else begin
            if (bus.load) target <= bus.pattern_in;
            presc   <= tick ? '0 : presc + PW'(1);
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            for (int i = 0; i < 8; i++) begin
                if (tick)
                    level[i] <= target[i] ? (level[i] == MAX ? level[i] : level[i] + PWM_BITS'(1))
                                          : (level[i] == '0  ? level[i] : level[i] - PWM_BITS'(1));
                // MAX forced on so full brightness has no gap at pwm_cnt == MAX
                led_q[i] <= (level[i] == MAX) | (level[i] > pwm_cnt);
            end
        end
    end
    always_comb begin
        busy_c = 1'b0;
        for (int i = 0; i < 8; i++) busy_c = busy_c | (level[i] != (target[i] ? MAX : '0));
    end
    assign bus.led  = led_q;
    assign bus.busy = busy_c;
endmodule

// File: tb/tb_led_fader.sv
// tb_led_fader: directed checks of led_fader with PWM_BITS=4, STEP_CYCLES=4
module tb_led_fader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   e = 0;
    int   ph = 0;
    int   vecs = 0;
    int   errs = 0;
    led_fader_if bus ();
    led_fader #(.PWM_BITS(4), .STEP_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    // e counts rising edges since reset release; ticks land on edges where e % 4 == 0
    function automatic int ramp(int x, int t0, int s, int d);
        int v;
        v = x < t0 ? s : s + d * ((x - t0) / 4 + 1);
        return v < 0 ? 0 : (v > 15 ? 15 : v);
    endfunction
    function automatic int lv(int x);
        case (ph)
            2: return ramp(x, 68, 0, 1);
            3: return ramp(x, 144, 0, 1);
            4: return ramp(x, 212, 15, -1);
            5: return x < 316 ? ramp(x, 292, 0, 1) : ramp(x, 316, 6, -1);
            6: return ramp(x, 352, 0, 1);
            7: return ramp(x, 416, 15, -1);
            default: return 0;
        endcase
    endfunction
    function automatic logic pw(int x);
        return lv(x) == 15 || lv(x) > x % 16;
    endfunction
    task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s ph%0d edge%0d got=%h exp=%h", tag, ph, e, got, exp);
        end
    endtask
    task automatic seg(int p, int last, int ld1, logic [7:0] p1, int ld2, logic [7:0] p2,
                       logic [7:0] fm, logic [7:0] om, int b0, int b1);
        ph = p;
        while (e < last) begin
            bus.load       = (e == ld1 - 1) || (e == ld2 - 1);
            bus.pattern_in = e < ld2 - 1 ? p1 : p2;
            @(posedge clk);
            @(negedge clk);
            e++;
            chk("led", bus.led, om | (pw(e - 1) ? fm : 8'h00));
            chk("busy", {7'b0, bus.busy}, {7'b0, e >= b0 && e < b1});
        end
        bus.load = 1'b0;
    endtask
    initial begin
        bus.load       = 1'b0;
        bus.pattern_in = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_led", bus.led, 8'h00);
        chk("rst_busy", {7'b0, bus.busy}, 8'h00);
        rst = 1'b0;
        seg(1, 64, -10, 8'h00, -10, 8'h00, 8'h00, 8'h00, 0, 0);
        seg(2, 140, 65, 8'h01, -10, 8'h01, 8'h01, 8'h00, 65, 124);
        seg(3, 208, 141, 8'hFF, -10, 8'hFF, 8'hFE, 8'h01, 141, 200);
        seg(4, 290, 209, 8'h00, -10, 8'h00, 8'hFF, 8'h00, 209, 268);
        seg(5, 344, 291, 8'h0F, 313, 8'h00, 8'h0F, 8'h00, 291, 336);
        seg(6, 412, 348, 8'hFF, -10, 8'hFF, 8'hFF, 8'h00, 348, 408);
        seg(7, 680, 413, 8'hA5, -10, 8'hA5, 8'h5A, 8'hA5, 413, 472);
        seg(8, 690, 681, 8'hA5, -10, 8'hA5, 8'h00, 8'hA5, 0, 0);
        bus.pattern_in = 8'h00;
        bus.load       = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_led", bus.led, 8'h00);
        chk("async_rst_busy", {7'b0, bus.busy}, 8'h00);
        @(negedge clk);
        chk("hold_rst_led", bus.led, 8'h00);
        rst = 1'b0;
        e   = 0;
        seg(1, 64, -10, 8'h00, -10, 8'h00, 8'h00, 8'h00, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
